// File: rtl/nco_sweep_ctl_if.sv
// Control and configuration bundle between a sweep master and nco_sweep_ctl.
// The NCO-facing signals (phi_inc_o, nco_clken, nco_valid) travel here as well.
interface nco_sweep_ctl_if #(
    parameter int APR = 20,
    parameter int NSW = 12,
    parameter int DWW = 16
);
    logic           start;
    logic           abort;
    logic           hold;
    logic [APR-1:0] cfg_start_inc;
    logic [APR-1:0] cfg_step_inc;
    logic [NSW-1:0] cfg_nsteps;
    logic [DWW-1:0] cfg_dwell;
    logic           cfg_loop;
    logic           nco_valid;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken;
    logic [NSW-1:0] step_idx;
    logic           busy;
    logic           sample_valid;
    logic           done;

    modport master (
        output start, abort, hold, cfg_start_inc, cfg_step_inc, cfg_nsteps,
               cfg_dwell, cfg_loop, nco_valid,
        input  phi_inc_o, nco_clken, step_idx, busy, sample_valid, done
    );

    modport slave (
        input  start, abort, hold, cfg_start_inc, cfg_step_inc, cfg_nsteps,
               cfg_dwell, cfg_loop, nco_valid,
        output phi_inc_o, nco_clken, step_idx, busy, sample_valid, done
    );
endinterface

// File: rtl/nco_sweep_ctl.sv
// Stepped-frequency sweep controller: walks an NCO phase increment through
// nsteps values, holding each for dwell enabled cycles, with hold/abort/loop.
module nco_sweep_ctl #(
    parameter int APR = 20,
    parameter int NSW = 12,
    parameter int DWW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    nco_sweep_ctl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [APR-1:0]        phi_q, phi_d;
    logic [APR-1:0]        start_inc_q, start_inc_d;
    logic signed [APR-1:0] step_q, step_d;
    logic [NSW-1:0]        idx_q, idx_d;
    logic [NSW-1:0]        nsteps_q, nsteps_d;
    logic [DWW-1:0]        dwell_q, dwell_d;
    logic [DWW-1:0]        dcnt_q, dcnt_d;
    logic                  loop_q, loop_d;
    logic                  busy_q, busy_d;
    logic                  run_q, run_d;
    logic                  done_q, done_d;

    function automatic logic [NSW-1:0] at_least_one_n(input logic [NSW-1:0] v);
        return (v == '0) ? NSW'(1) : v;
    endfunction

    function automatic logic [DWW-1:0] at_least_one_d(input logic [DWW-1:0] v);
        return (v == '0) ? DWW'(1) : v;
    endfunction

    always_comb begin
        state_d     = state_q;
        phi_d       = phi_q;
        start_inc_d = start_inc_q;
        step_d      = step_q;
        idx_d       = idx_q;
        nsteps_d    = nsteps_q;
        dwell_d     = dwell_q;
        dcnt_d      = dcnt_q;
        loop_d      = loop_q;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        start_inc_d = bus.cfg_start_inc;
                        step_d      = bus.cfg_step_inc;
                        nsteps_d    = at_least_one_n(bus.cfg_nsteps);
                        dwell_d     = at_least_one_d(bus.cfg_dwell);
                        loop_d      = bus.cfg_loop;
                        phi_d       = bus.cfg_start_inc;
                        idx_d       = '0;
                        state_d     = PRIME;
                    end
                end
                PRIME: begin
                    if (!bus.hold && bus.nco_valid) begin
                        dcnt_d  = dwell_q;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!bus.hold) begin
                        // Last dwell cycle: next increment lands on the very next cycle.
                        if (dcnt_q == DWW'(1)) begin
                            if (idx_q < nsteps_q - NSW'(1)) begin
                                phi_d  = phi_q + $unsigned(step_q);
                                idx_d  = idx_q + NSW'(1);
                                dcnt_d = dwell_q;
                            end else if (loop_q) begin
                                phi_d  = start_inc_q;
                                idx_d  = '0;
                                dcnt_d = dwell_q;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            dcnt_d = dcnt_q - DWW'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == PRIME) || (state_d == RUN);
        run_d  = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phi_q       <= '0;
            start_inc_q <= '0;
            step_q      <= '0;
            idx_q       <= '0;
            nsteps_q    <= '0;
            dwell_q     <= '0;
            dcnt_q      <= '0;
            loop_q      <= 1'b0;
            busy_q      <= 1'b0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phi_q       <= phi_d;
            start_inc_q <= start_inc_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            nsteps_q    <= nsteps_d;
            dwell_q     <= dwell_d;
            dcnt_q      <= dcnt_d;
            loop_q      <= loop_d;
            busy_q      <= busy_d;
            run_q       <= run_d;
            done_q      <= done_d;
        end
    end

    // hold must stall the NCO in the same cycle, so it gates the registered state directly.
    assign bus.phi_inc_o    = phi_q;
    assign bus.step_idx     = idx_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.nco_clken    = busy_q & ~bus.hold;
    assign bus.sample_valid = run_q & ~bus.hold & bus.nco_valid;
endmodule

// File: tb/tb_nco_sweep_ctl.sv
// Self-checking bench for nco_sweep_ctl: directed scenarios plus random sweeps
// compared against a step/dwell trace computed from the sweep definition.
module tb_nco_sweep_ctl;
    localparam int APR = 20;
    localparam int NSW = 12;
    localparam int DWW = 16;
    localparam int TW  = NSW + APR;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nco_sweep_ctl_if #(.APR(APR), .NSW(NSW), .DWW(DWW)) bus ();

    nco_sweep_ctl #(.APR(APR), .NSW(NSW), .DWW(DWW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // NCO stand-in: out_valid rises after two enabled cycles of a sweep.
    int ncnt;
    always @(posedge clk) begin
        if (!bus.busy) ncnt <= 0;
        else if (bus.nco_clken && ncnt < 2) ncnt <= ncnt + 1;
    end
    assign bus.nco_valid = (ncnt >= 2);

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [APR-1:0] ref_phi(input logic [APR-1:0] si, input logic [APR-1:0] st,
                                               input int s);
        logic [31:0] t;
        t = 32'(si) + 32'(s) * 32'(st);
        return t[APR-1:0];
    endfunction

    task automatic drive_start(input logic [APR-1:0] si, input logic [APR-1:0] st,
                               input int n, input int d, input logic lp);
        bus.cfg_start_inc = si;
        bus.cfg_step_inc  = st;
        bus.cfg_nsteps    = NSW'(n);
        bus.cfg_dwell     = DWW'(d);
        bus.cfg_loop      = lp;
        bus.start         = 1'b1;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_sweep(input string tag, input logic [APR-1:0] si, input logic [APR-1:0] st,
                             input int n, input int d, input int hold_at, input int hold_len,
                             input bit disturb);
        logic [TW-1:0] expq[$];
        logic [TW-1:0] obsq[$];
        int ne, de, k, done_k, hold_left, hold_bad, bad;
        bit hold_used;
        ne = (n == 0) ? 1 : n;
        de = (d == 0) ? 1 : d;
        for (int s = 0; s < ne; s++)
            for (int j = 0; j < de; j++)
                expq.push_back({NSW'(s), ref_phi(si, st, s)});
        k = 0; done_k = -1; hold_left = 0; hold_bad = 0; hold_used = 1'b0;
        drive_start(si, st, n, d, 1'b0);
        for (int c = 0; c < 300 && done_k < 0; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            k++;
            if (disturb && k == 5)
                drive_start(APR'($urandom), APR'($urandom), $urandom_range(1, 9),
                            $urandom_range(1, 9), 1'b1);
            if (!hold_used && hold_len > 0 && obsq.size() == hold_at) begin
                hold_left = hold_len;
                hold_used = 1'b1;
            end
            bus.hold = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            #1;
            if (bus.hold && (bus.nco_clken || bus.sample_valid)) hold_bad++;
            if (bus.sample_valid) obsq.push_back({bus.step_idx, bus.phi_inc_o});
            if (bus.done) begin
                done_k = k;
                chk({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
            end
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        chk({tag, " done_cycle"}, 64'(done_k), 64'(4 + ne * de + hold_len));
        chk({tag, " sample_count"}, 64'(obsq.size()), 64'(expq.size()));
        bad = -1;
        for (int i = 0; i < obsq.size() && i < expq.size(); i++)
            if (bad < 0 && obsq[i] !== expq[i]) bad = i;
        chk({tag, " first_bad_sample"}, 64'(bad), 64'(-1));
        if (bad >= 0) chk({tag, " idx_phi_at_bad"}, 64'(obsq[bad]), 64'(expq[bad]));
        if (hold_len > 0) chk({tag, " hold_gating"}, 64'(hold_bad), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        chk({tag, " idle_busy_done_clken"}, {61'd0, bus.busy, bus.done, bus.nco_clken}, 64'd0);
        chk({tag, " phi_held"}, 64'(bus.phi_inc_o), 64'(ref_phi(si, st, ne - 1)));
        chk({tag, " idx_held"}, 64'(bus.step_idx), 64'(ne - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [APR-1:0] si, st, phi_before;
        logic [APR-1:0] lq[$];
        int dcount, bad;

        bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
        bus.cfg_start_inc = '0; bus.cfg_step_inc = '0; bus.cfg_nsteps = '0;
        bus.cfg_dwell = '0; bus.cfg_loop = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset outputs", {bus.phi_inc_o, bus.step_idx, bus.busy, bus.nco_clken,
                              bus.sample_valid, bus.done}, '0);
        reset_n = 1'b1;

        run_sweep("s1", 20'h01000, 20'h00100, 3, 4, 0, 0, 1'b0);
        run_sweep("s3wrap", 20'h00000, 20'hFFFFF, 2, 3, 0, 0, 1'b0);
        run_sweep("s3zero", 20'h12345, 20'h00011, 0, 0, 0, 0, 1'b0);
        run_sweep("s4hold", 20'h01000, 20'h00100, 3, 4, 5, 3, 1'b0);
        run_sweep("s5disturb", 20'h0ABCD, 20'hFF000, 3, 4, 0, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int n, d, ha, hl;
            n = $urandom_range(1, 5);
            d = $urandom_range(1, 5);
            ha = (n * d >= 2) ? $urandom_range(1, n * d - 1) : 0;
            hl = (n * d >= 2) ? $urandom_range(0, 4) : 0;
            run_sweep($sformatf("rnd%0d", r), APR'($urandom), APR'($urandom), n, d, ha, hl,
                      1'($urandom_range(0, 1)));
        end

        // Looping sweep: alternating increments, no done, then abort.
        si = APR'($urandom);
        st = APR'($urandom);
        dcount = 0;
        drive_start(si, st, 2, 2, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.sample_valid) lq.push_back(bus.phi_inc_o);
            if (bus.done) dcount++;
        end
        chk("s2 done_count", 64'(dcount), 64'd0);
        chk("s2 sample_count", 64'(lq.size()), 64'd37);
        bad = -1;
        for (int i = 0; i < lq.size(); i++)
            if (bad < 0 && lq[i] !== ref_phi(si, st, (i / 2) % 2)) bad = i;
        chk("s2 first_bad_sample", 64'(bad), 64'(-1));
        phi_before = bus.phi_inc_o;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        chk("s2 abort_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        chk("s2 abort_phi_held", 64'(bus.phi_inc_o), 64'(phi_before));

        // start together with abort in IDLE must be ignored.
        phi_before = bus.phi_inc_o;
        drive_start(20'h55555, 20'h00001, 2, 2, 1'b0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #1;
        chk("s5 start_abort_busy", 64'(bus.busy), 64'd0);
        chk("s5 start_abort_phi", 64'(bus.phi_inc_o), 64'(phi_before));

        // Asynchronous reset in the middle of RUN.
        drive_start(20'h01000, 20'h00100, 3, 4, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("s6 running_before_reset", {62'd0, bus.busy, bus.sample_valid}, 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6 async_reset_outputs", {bus.phi_inc_o, bus.step_idx, bus.busy, bus.nco_clken,
                                       bus.sample_valid, bus.done}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        run_sweep("s6fresh", 20'h01000, 20'h00100, 3, 4, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nco_sweep_ctl.md
NCO_SWEEP_CTL -- requirements
Module: nco_sweep_ctl

Interface
REQ-001 Parameter APR, default 20, phase-increment width; matches the NCO phase accumulator width.
REQ-002 Parameter NSW, default 12, step-count and step-index width.
REQ-003 Parameter DWW, default 16, dwell-counter width.
REQ-004 clk  input  1  single clock; all state is updated on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a sweep.
REQ-007 abort  input  1  terminates the sweep.
REQ-008 hold  input  1  pauses the sweep and stalls the NCO.
REQ-009 cfg_start_inc  input  APR  first phase increment.
REQ-010 cfg_step_inc  input  APR  per-step increment delta, two's complement.
REQ-011 cfg_nsteps  input  NSW  number of frequency steps.
REQ-012 cfg_dwell  input  DWW  clock-enabled cycles per step.
REQ-013 cfg_loop  input  1  1 = repeat the sweep indefinitely.
REQ-014 nco_valid  input  1  NCO out_valid.
REQ-015 phi_inc_o  output  APR  drives NCO phi_inc_i.
REQ-016 nco_clken  output  1  drives NCO clken.
REQ-017 step_idx  output  NSW  current step index.
REQ-018 busy  output  1  high in PRIME and RUN.
REQ-019 sample_valid  output  1  marks NCO output samples that belong to the sweep.
REQ-020 done  output  1  one-cycle pulse at normal sweep completion.

Function
REQ-021 The FSM SHALL have states IDLE, PRIME, RUN and DONE, and all outputs SHALL be registered.
REQ-022 In IDLE, a start with abort=0 SHALL capture all cfg_* inputs into shadow registers, load phi_inc_o=cfg_start_inc and step_idx=0, and move to PRIME.
REQ-023 The cfg_* inputs SHALL be ignored outside the start-capture cycle.
REQ-024 The start input SHALL be ignored when the FSM is not in IDLE.
REQ-025 A captured cfg_nsteps of 0 SHALL be treated as 1, and a captured cfg_dwell of 0 SHALL be treated as 1.
REQ-026 nco_clken SHALL equal 1 in PRIME and RUN when hold=0, and 0 in all other cases.
REQ-027 PRIME SHALL remain until nco_valid=1 is sampled with nco_clken=1, then load dwell_cnt=dwell and move to RUN.
REQ-028 In RUN with hold=0, dwell_cnt SHALL decrement each cycle.
REQ-029 On the cycle where dwell_cnt=1 in RUN with step_idx<nsteps-1: phi_inc_o SHALL become phi_inc_o+step (mod 2^APR, wrap silently), step_idx SHALL increment, and dwell_cnt SHALL reload.
REQ-030 On the cycle where dwell_cnt=1 in RUN with step_idx=nsteps-1 and loop=1: phi_inc_o SHALL become start_inc, step_idx SHALL become 0, dwell_cnt SHALL reload, and no done pulse SHALL occur.
REQ-031 On the cycle where dwell_cnt=1 in RUN with step_idx=nsteps-1 and loop=0: the FSM SHALL move to DONE.
REQ-032 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-033 phi_inc_o and step_idx SHALL hold their last values in DONE and IDLE.
REQ-034 With hold=1 in PRIME or RUN, all counters, phi_inc_o and the state SHALL freeze, and nco_clken=0.
REQ-035 The cycle following hold deassertion SHALL resume exactly where the sweep paused.
REQ-036 abort=1 in any state SHALL force IDLE on the next edge with done=0 and phi_inc_o held.
REQ-037 abort SHALL have priority over start, hold and step events in the same cycle.
REQ-038 sample_valid SHALL equal 1 when state=RUN, hold=0 and nco_valid=1; each step therefore yields exactly dwell sample_valid cycles.
REQ-039 The phase-increment change SHALL take effect on phi_inc_o in the cycle after the last dwell cycle, with no gap cycle between steps.

Reset
REQ-040 Asserting reset_n=0 SHALL, asynchronously at any time (including mid-sweep), force state=IDLE, phi_inc_o=0, step_idx=0, dwell_cnt=0, shadow registers=0, and busy=nco_clken=sample_valid=done=0.
REQ-041 After reset_n deassertion, the first start SHALL be accepted on the first rising edge.

Verification
REQ-042 Scenario 1: start_inc=0x01000, step=0x00100, nsteps=3, dwell=4, loop=0, nco_valid high after 2 clken cycles -> phi_inc_o sequence 0x01000, 0x01100, 0x01200; 12 sample_valid cycles; one done pulse; busy low afterwards.
REQ-043 Scenario 2: loop=1, nsteps=2, dwell=2 -> phi_inc_o alternates start/start+step every 2 RUN cycles; done never asserts; abort -> IDLE next edge with done=0.
REQ-044 Scenario 3: step=0xFFFFF (-1), start_inc=0x00000, nsteps=2 -> second increment is 0xFFFFF (wrap); nsteps=0 and dwell=0 -> one step of one cycle, then done.
REQ-045 Scenario 4: hold pulsed 3 cycles mid-dwell -> nco_clken=0 and sample_valid=0 for those 3 cycles; total sample_valid count unchanged; done delayed by exactly 3 cycles.
REQ-046 Scenario 5: start during RUN -> ignored; start and abort in the same IDLE cycle -> remain IDLE; cfg change mid-sweep -> no effect.
REQ-047 Scenario 6: reset_n low during RUN between clock edges -> outputs zero immediately, before the next clock edge; a fresh start after release -> a correct sweep from step 0.
